// File: rtl/bg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bg_pkg
// Description : Shared constants and types for the background compositor.
// Revision    : 1.0 - initial release
// ============================================================================
package bg_pkg;

    localparam logic [2:0] CFG_HORIZON    = 3'd0;
    localparam logic [2:0] CFG_GROUND     = 3'd1;
    localparam logic [2:0] CFG_SKY_IDX    = 3'd2;
    localparam logic [2:0] CFG_GROUND_IDX = 3'd3;
    localparam logic [2:0] CFG_GRASS_BASE = 3'd4;
    localparam logic [2:0] CFG_SCROLL     = 3'd5;

    localparam int DEF_HORIZON_Y  = 300;
    localparam int DEF_GROUND_Y   = 400;
    localparam int DEF_SKY_IDX    = 0;
    localparam int DEF_GROUND_IDX = 7;
    localparam int DEF_GRASS_BASE = 8;
    localparam int DEF_SCROLL     = 0;

    typedef enum logic [1:0] {
        BAND_SKY    = 2'd0,
        BAND_GRASS  = 2'd1,
        BAND_GROUND = 2'd2
    } band_e;

endpackage
`default_nettype wire

// File: rtl/bg_pattern_ram.sv
`default_nettype none
// ============================================================================
// Module      : bg_pattern_ram
// Description : Grass texture store; one write port, one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module bg_pattern_ram #(
    parameter int DEPTH = 5200,
    parameter int TEX_W = 3,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [TEX_W-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [TEX_W-1:0] rdata
);

    logic [TEX_W-1:0] mem_q [DEPTH];
    logic [TEX_W-1:0] rdata_q;

    // Non-blocking read of the same address returns the pre-write texel.
    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < (AW + 1)'(DEPTH))) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/bg_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : bg_layer_compositor
// Description : Two-stage sky / scrolling-grass / ground background compositor.
// Revision    : 1.0 - initial release
// ============================================================================
module bg_layer_compositor
    import bg_pkg::*;
#(
    parameter int IDX_W     = 9,
    parameter int COORD_W   = 10,
    parameter int PAT_W     = 52,
    parameter int PAT_H     = 100,
    parameter int TEX_W     = 3,
    parameter int TRANSP_W  = 4,
    localparam int PAT_AW   = $clog2(PAT_W * PAT_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               line_start,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [IDX_W-1:0]   indexIn,
    output logic               out_valid,
    output logic [IDX_W-1:0]   indexOut,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [15:0]        cfg_data,
    input  logic               pat_we,
    input  logic [PAT_AW-1:0]  pat_addr,
    input  logic [TEX_W-1:0]   pat_data
);

    localparam int COL_W = $clog2(PAT_W);

    logic [COORD_W-1:0] horizon_sh_q, horizon_sh_d, horizon_act_q, horizon_act_d;
    logic [COORD_W-1:0] ground_sh_q, ground_sh_d, ground_act_q, ground_act_d;
    logic [IDX_W-1:0]   sky_sh_q, sky_sh_d, sky_act_q, sky_act_d;
    logic [IDX_W-1:0]   gidx_sh_q, gidx_sh_d, gidx_act_q, gidx_act_d;
    logic [IDX_W-1:0]   base_sh_q, base_sh_d, base_act_q, base_act_d;
    logic [COL_W-1:0]   scroll_sh_q, scroll_sh_d, scroll_act_q, scroll_act_d;
    logic [COL_W-1:0]   col_q, col_d, col_cur;

    logic [COORD_W-1:0] row;
    logic               row_in, rd_en;
    logic [PAT_AW-1:0]  rd_addr;
    logic [IDX_W-1:0]   bg_idx;
    band_e              band;
    logic [TEX_W-1:0]   tex_rdata, texel;
    logic [IDX_W-1:0]   band_idx;

    logic               valid_s1_q, valid_s1_d, tex_ok_s1_q, tex_ok_s1_d;
    logic [IDX_W-1:0]   index_s1_q, index_s1_d, bg_s1_q, bg_s1_d;
    band_e              band_s1_q, band_s1_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   index_out_q, index_out_d;

    logic unused_x;
    assign unused_x = ^x;

    // Shadow writes feed the commit path directly so a same-cycle write is taken.
    always_comb begin
        horizon_sh_d = horizon_sh_q;
        ground_sh_d  = ground_sh_q;
        sky_sh_d     = sky_sh_q;
        gidx_sh_d    = gidx_sh_q;
        base_sh_d    = base_sh_q;
        scroll_sh_d  = scroll_sh_q;
        if (cfg_we) begin
            case (cfg_addr)
                CFG_HORIZON:    horizon_sh_d = cfg_data[COORD_W-1:0];
                CFG_GROUND:     ground_sh_d  = cfg_data[COORD_W-1:0];
                CFG_SKY_IDX:    sky_sh_d     = cfg_data[IDX_W-1:0];
                CFG_GROUND_IDX: gidx_sh_d    = cfg_data[IDX_W-1:0];
                CFG_GRASS_BASE: base_sh_d    = cfg_data[IDX_W-1:0];
                CFG_SCROLL: begin
                    if (cfg_data < 16'(PAT_W)) begin
                        scroll_sh_d = cfg_data[COL_W-1:0];
                    end
                end
                default: ;
            endcase
        end
        horizon_act_d = frame_start ? horizon_sh_d : horizon_act_q;
        ground_act_d  = frame_start ? ground_sh_d  : ground_act_q;
        sky_act_d     = frame_start ? sky_sh_d     : sky_act_q;
        gidx_act_d    = frame_start ? gidx_sh_d    : gidx_act_q;
        base_act_d    = frame_start ? base_sh_d    : base_act_q;
        scroll_act_d  = frame_start ? scroll_sh_d  : scroll_act_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            horizon_sh_q  <= COORD_W'(DEF_HORIZON_Y);
            horizon_act_q <= COORD_W'(DEF_HORIZON_Y);
            ground_sh_q   <= COORD_W'(DEF_GROUND_Y);
            ground_act_q  <= COORD_W'(DEF_GROUND_Y);
            sky_sh_q      <= IDX_W'(DEF_SKY_IDX);
            sky_act_q     <= IDX_W'(DEF_SKY_IDX);
            gidx_sh_q     <= IDX_W'(DEF_GROUND_IDX);
            gidx_act_q    <= IDX_W'(DEF_GROUND_IDX);
            base_sh_q     <= IDX_W'(DEF_GRASS_BASE);
            base_act_q    <= IDX_W'(DEF_GRASS_BASE);
            scroll_sh_q   <= COL_W'(DEF_SCROLL);
            scroll_act_q  <= COL_W'(DEF_SCROLL);
        end else begin
            horizon_sh_q  <= horizon_sh_d;
            horizon_act_q <= horizon_act_d;
            ground_sh_q   <= ground_sh_d;
            ground_act_q  <= ground_act_d;
            sky_sh_q      <= sky_sh_d;
            sky_act_q     <= sky_act_d;
            gidx_sh_q     <= gidx_sh_d;
            gidx_act_q    <= gidx_act_d;
            base_sh_q     <= base_sh_d;
            base_act_q    <= base_act_d;
            scroll_sh_q   <= scroll_sh_d;
            scroll_act_q  <= scroll_act_d;
        end
    end

    // Stage 1: classify against the pre-commit active copy and launch the RAM read.
    always_comb begin
        col_cur = line_start ? scroll_act_q : col_q;
        col_d   = col_cur;
        if (in_valid) begin
            col_d = (col_cur == COL_W'(PAT_W - 1)) ? '0 : col_cur + COL_W'(1);
        end
        row     = y - horizon_act_q;
        row_in  = row < COORD_W'(PAT_H);
        rd_addr = PAT_AW'(row) * PAT_AW'(PAT_W) + PAT_AW'(col_cur);
        if (y < horizon_act_q) begin
            band   = BAND_SKY;
            bg_idx = sky_act_q;
        end else if (y < ground_act_q) begin
            band   = BAND_GRASS;
            bg_idx = base_act_q;
        end else begin
            band   = BAND_GROUND;
            bg_idx = gidx_act_q;
        end
        rd_en       = in_valid && (band == BAND_GRASS) && row_in;
        valid_s1_d  = in_valid;
        index_s1_d  = indexIn;
        band_s1_d   = band;
        tex_ok_s1_d = row_in;
        bg_s1_d     = bg_idx;
    end

    bg_pattern_ram #(
        .DEPTH (PAT_W * PAT_H),
        .TEX_W (TEX_W)
    ) u_pattern_ram (
        .clk   (clk),
        .we    (pat_we),
        .waddr (pat_addr),
        .wdata (pat_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (tex_rdata)
    );

    // Stage 2: final mux; output index holds while no pixel is retiring.
    always_comb begin
        texel       = tex_ok_s1_q ? tex_rdata : '0;
        band_idx    = (band_s1_q == BAND_GRASS) ? bg_s1_q + IDX_W'(texel) : bg_s1_q;
        out_valid_d = valid_s1_q;
        index_out_d = index_out_q;
        if (valid_s1_q) begin
            index_out_d = (index_s1_q[TRANSP_W-1:0] == '0) ? band_idx : index_s1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            valid_s1_q  <= 1'b0;
            index_s1_q  <= '0;
            band_s1_q   <= BAND_SKY;
            tex_ok_s1_q <= 1'b0;
            bg_s1_q     <= '0;
            out_valid_q <= 1'b0;
            index_out_q <= '0;
        end else begin
            col_q       <= col_d;
            valid_s1_q  <= valid_s1_d;
            index_s1_q  <= index_s1_d;
            band_s1_q   <= band_s1_d;
            tex_ok_s1_q <= tex_ok_s1_d;
            bg_s1_q     <= bg_s1_d;
            out_valid_q <= out_valid_d;
            index_out_q <= index_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign indexOut  = index_out_q;

endmodule
`default_nettype wire

// File: tb/tb_bg_layer_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bg_layer_compositor
// Description : Directed vectors plus randomized traffic against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bg_layer_compositor;

    localparam int IDX_W  = 9;
    localparam int COORD_W = 10;
    localparam int PAT_W  = 52;
    localparam int PAT_H  = 100;
    localparam int TEX_W  = 3;
    localparam int PAT_AW = 13;
    localparam int NPIX   = PAT_W * PAT_H;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               frame_start = 1'b0, line_start = 1'b0, in_valid = 1'b0;
    logic [COORD_W-1:0] x = '0, y = '0;
    logic [IDX_W-1:0]   indexIn = '0;
    logic               out_valid;
    logic [IDX_W-1:0]   indexOut;
    logic               cfg_we = 1'b0;
    logic [2:0]         cfg_addr = '0;
    logic [15:0]        cfg_data = '0;
    logic               pat_we = 1'b0;
    logic [PAT_AW-1:0]  pat_addr = '0;
    logic [TEX_W-1:0]   pat_data = '0;

    bg_layer_compositor dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .in_valid(in_valid), .x(x), .y(y), .indexIn(indexIn),
        .out_valid(out_valid), .indexOut(indexOut),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Frame-level model: register file, texture image, current column, output register.
    int defaults [6] = '{300, 400, 0, 7, 8, 0};
    int sh [6];
    int act [6];
    int pat [NPIX];
    int mcol = 0;
    bit prev_v = 0;
    int prev_idx = 0;
    int last_idx = 0;
    int got [$];

    typedef struct {
        int yv;
        int iv;
        int exp;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int model_pix(input int yv, input int iv, input int c);
        int bg, row, tex;
        if (yv < act[0]) bg = act[2];
        else if (yv < act[1]) begin
            row = yv - act[0];
            tex = (row >= PAT_H) ? 0 : pat[row * PAT_W + c];
            bg  = (act[4] + tex) % (1 << IDX_W);
        end else bg = act[3];
        return ((iv % 16) == 0) ? bg : iv;
    endfunction

    task automatic model_cfg(input int a, input int d);
        case (a)
            0, 1:    sh[a] = d % (1 << COORD_W);
            2, 3, 4: sh[a] = d % (1 << IDX_W);
            5:       if (d < PAT_W) sh[5] = d;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            sh[i]  = defaults[i];
            act[i] = defaults[i];
        end
        mcol = 0; prev_v = 0; prev_idx = 0; last_idx = 0;
    endtask

    task automatic clear_inputs();
        in_valid = 0; frame_start = 0; line_start = 0; cfg_we = 0; pat_we = 0;
    endtask

    // One clock: evaluate the model on current inputs, advance, compare previous pixel.
    task automatic step();
        int c, cur_idx;
        bit cur_v;
        c = line_start ? act[5] : mcol;
        cur_v = in_valid;
        cur_idx = model_pix(int'(y), int'(indexIn), c);
        if (pat_we && int'(pat_addr) < NPIX) pat[pat_addr] = int'(pat_data);
        if (cfg_we) model_cfg(int'(cfg_addr), int'(cfg_data));
        if (frame_start) act = sh;
        mcol = in_valid ? (c + 1) % PAT_W : c;
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), int'(prev_v));
        if (prev_v) last_idx = prev_idx;
        check("indexOut", int'(indexOut), last_idx);
        if (out_valid) got.push_back(int'(indexOut));
        prev_v = cur_v;
        prev_idx = cur_idx;
        clear_inputs();
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_indexOut", int'(indexOut), 0);
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        got.delete();
        clear_inputs();
    endtask

    task automatic pix(input int yv, input int iv);
        in_valid = 1; y = COORD_W'(yv); indexIn = IDX_W'(iv);
        step();
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_we = 1; cfg_addr = 3'(a); cfg_data = 16'(d);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic frame();
        frame_start = 1;
        step();
    endtask

    task automatic expect_got(input string name, input int e0, input int e1, input int n);
        check({name, "_count"}, got.size(), n);
        if (got.size() >= 1) check({name, "_0"}, got[0], e0);
        if (n > 1 && got.size() >= 2) check({name, "_1"}, got[1], e1);
        got.delete();
    endtask

    initial begin
        vec_t tbl [5];
        int exp4 [4];
        tbl[0] = '{10,  'h010, 0};
        tbl[1] = '{350, 'h010, 9};
        tbl[2] = '{450, 'h010, 7};
        tbl[3] = '{10,  'h013, 'h013};
        tbl[4] = '{10,  'h020, 0};
        exp4 = '{10, 11, 8, 9};

        model_reset();
        #2;
        do_reset();
        for (int i = 0; i < NPIX; i++) begin
            pat_we = 1; pat_addr = PAT_AW'(i); pat_data = 3'd1;
            step();
        end
        do_reset();

        // Defaults and passthrough, streamed back to back.
        for (int i = 0; i < 5; i++) pix(tbl[i].yv, tbl[i].iv);
        idle(2);
        check("vec_count", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("vec_idx", got[i], tbl[i].exp);
        got.delete();

        // Scroll with wrap across the pattern edge.
        for (int c = 0; c < PAT_W; c++) begin
            pat_we = 1; pat_addr = PAT_AW'(c); pat_data = TEX_W'(c % 8);
            step();
        end
        cfg_write(5, 50);
        frame();
        line_start = 1;
        step();
        got.delete();
        for (int i = 0; i < 4; i++) pix(300, 0);
        idle(2);
        check("scroll_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("scroll_idx", got[i], exp4[i]);
        got.delete();

        // Shadow only takes effect at frame start; same-cycle write commits.
        cfg_write(0, 200);
        got.delete();
        pix(250, 0); idle(2);
        expect_got("shadow_pre", 0, 0, 1);
        frame();
        pix(250, 0); idle(2);
        expect_got("shadow_post", 9, 0, 1);
        cfg_we = 1; cfg_addr = 3'd2; cfg_data = 16'd5; frame_start = 1;
        step();
        got.delete();
        pix(10, 0); idle(2);
        expect_got("write_through", 5, 0, 1);

        // Row past the pattern height, empty grass band, out-of-range scroll.
        cfg_write(0, 300);
        cfg_write(1, 450);
        frame();
        got.delete();
        pix(400, 0); idle(2);
        expect_got("row_oob", 8, 0, 1);
        cfg_write(1, 300);
        frame();
        got.delete();
        pix(299, 0); pix(300, 0); idle(2);
        expect_got("no_grass", 5, 7, 2);
        cfg_write(5, 52);
        cfg_write(1, 400);
        frame();
        line_start = 1;
        step();
        got.delete();
        pix(300, 0); idle(2);
        expect_got("scroll_drop", 10, 0, 1);

        // Reset with pixels in flight.
        pix(10, 'h013);
        pix(10, 'h015);
        do_reset();
        idle(3);
        check("flush_count", got.size(), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            x = COORD_W'(i);
            y = COORD_W'($urandom_range(0, 700));
            indexIn = ($urandom_range(0, 1) != 0) ? IDX_W'($urandom & 32'h1F0) : IDX_W'($urandom);
            line_start = ($urandom_range(0, 15) == 0);
            frame_start = ($urandom_range(0, 31) == 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_addr = 3'($urandom_range(0, 7));
            if (cfg_addr < 3'd2) cfg_data = 16'($urandom_range(0, 700));
            else if (cfg_addr == 3'd5) cfg_data = 16'($urandom_range(0, 63));
            else cfg_data = 16'($urandom);
            pat_we = ($urandom_range(0, 3) == 0);
            pat_addr = PAT_AW'($urandom_range(0, NPIX - 1));
            pat_data = TEX_W'($urandom);
            step();
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
